// File: rtl/sub_pkg.sv
// Shared types and limits for the bit-serial subtractor controller and its cell.
// Supported operand widths are WIDTH_MIN..WIDTH_MAX.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = x - y - bin, with the borrow out of this bit in bout.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // A borrow is needed when y + bin exceeds x.
    assign bout = (~x & (y | bin)) | (y & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: feeds one full_sub cell LSB first over WIDTH cycles and
// presents diff = a - b with the final borrow through a start/done handshake.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH);

    sub_state_t       state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sb_reg;
    logic [WIDTH-2:0] acc_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bf_reg, borrow_reg;
    logic [CW-1:0]    cnt_reg;

    logic             dbit, bout, last_bit;
    logic [WIDTH-1:0] acc_shifted;

    full_sub u_cell (
        .x    (sa_reg[0]),
        .y    (sb_reg[0]),
        .bin  (bf_reg),
        .d    (dbit),
        .bout (bout)
    );

    // The current bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0.
    assign acc_shifted = {dbit, acc_reg};
    assign last_bit    = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sa_reg     <= '0;
            sb_reg     <= '0;
            acc_reg    <= '0;
            diff_reg   <= '0;
            bf_reg     <= 1'b0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sa_reg  <= a;
                        sb_reg  <= b;
                        acc_reg <= '0;
                        bf_reg  <= 1'b0;
                        cnt_reg <= '0;
                    end
                end
                RUN: begin
                    sa_reg  <= sa_reg >> 1;
                    sb_reg  <= sb_reg >> 1;
                    acc_reg <= acc_shifted[WIDTH-1:1];
                    bf_reg  <= bout;
                    if (last_bit) begin
                        // Outputs move only here, so no partial result is ever visible.
                        diff_reg   <= acc_shifted;
                        borrow_reg <= bout;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == DONE);
    assign diff   = diff_reg;
    assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench: three DUT widths (8, 2, 16) run in parallel, each with its own
// driver that queues (a - b) mod 2^W and (a < b), and a monitor that checks every cycle.
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;
    bit fin [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int W = (gi == 0) ? 8 : (gi == 1) ? 2 : 16;
        localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

        logic         rst_n, start, busy, done, borrow;
        logic [W-1:0] a, b, diff;

        serial_sub_ctrl #(.WIDTH(W)) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start),
            .a      (a),
            .b      (b),
            .busy   (busy),
            .done   (done),
            .diff   (diff),
            .borrow (borrow)
        );

        int          q_e0 [$];
        logic [63:0] q_d  [$];
        bit          q_b  [$];
        int          next_ok = 0;
        logic [63:0] hold_d  = '0;
        bit          hold_b  = 1'b0;

        // Waits until the DUT can accept, toggling start/a/b randomly while it cannot,
        // then issues one request and keeps start high for 'hold' further edges.
        task automatic issue(input logic [63:0] x, input logic [63:0] y, input int hold);
            @(negedge clk);
            while (cyc + 1 < next_ok) begin
                start = 1'($urandom_range(0, 1));
                a     = W'($urandom);
                b     = W'($urandom);
                @(negedge clk);
            end
            start = 1'b1;
            a     = W'(x);
            b     = W'(y);
            q_e0.push_back(cyc + 1);
            q_d.push_back((x - y) & MASK);
            q_b.push_back((x & MASK) < (y & MASK));
            next_ok = cyc + 1 + W + 2;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                a = W'($urandom);
                b = W'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic apply_reset();
            rst_n = 1'b0;
            q_e0.delete();
            q_d.delete();
            q_b.delete();
            next_ok = 0;
            hold_d  = '0;
            hold_b  = 1'b0;
            #1;
            check($sformatf("w%0d_rst_busy", W), 64'(busy), 64'd0);
            check($sformatf("w%0d_rst_done", W), 64'(done), 64'd0);
            check($sformatf("w%0d_rst_diff", W), 64'(diff), 64'd0);
            check($sformatf("w%0d_rst_borrow", W), 64'(borrow), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
        endtask

        initial begin
            logic [63:0] dir_a [4] = '{64'h5A, 64'h00, 64'hFF, 64'h80};
            logic [63:0] dir_b [4] = '{64'h3C, 64'h01, 64'hFF, 64'h7F};
            int n_rand;
            start = 1'b0;
            a     = '0;
            b     = '0;
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            apply_reset();

            for (int i = 0; i < 4; i++) issue(dir_a[i], dir_b[i], 0);

            // Start held through the whole operation while a/b change: one operation only.
            issue(64'h96 & MASK, 64'h2D & MASK, W + 1);
            issue(64'h11 & MASK, 64'h22 & MASK, 0);

            // Abort mid-RUN, then a fresh operation.
            issue(64'($urandom), 64'($urandom), 0);
            if (W > 4) repeat (3) @(negedge clk);
            apply_reset();
            issue(64'h80, 64'h7F, 0);

            if (W == 2)
                for (int x = 0; x < 4; x++)
                    for (int y = 0; y < 4; y++)
                        issue(64'(x), 64'(y), 0);

            n_rand = (W == 16) ? 1000 : 100;
            for (int i = 0; i < n_rand; i++) begin
                issue(64'($urandom), 64'($urandom), 0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end

            repeat (W + 4) @(negedge clk);
            check($sformatf("w%0d_pending_at_end", W), 64'(q_e0.size()), 64'd0);
            fin[gi] = 1'b1;
        end

        initial begin
            bit exp_busy, exp_done;
            forever begin
                @(posedge clk);
                #1;
                if (rst_n !== 1'b1) continue;
                exp_busy = (q_e0.size() > 0) && (cyc >= q_e0[0]) && (cyc < q_e0[0] + W);
                exp_done = (q_e0.size() > 0) && (cyc == q_e0[0] + W);
                check($sformatf("w%0d_busy", W), 64'(busy), 64'(exp_busy));
                check($sformatf("w%0d_done", W), 64'(done), 64'(exp_done));
                if (done === 1'b1 || exp_done) begin
                    if (q_e0.size() == 0) begin
                        check($sformatf("w%0d_unexpected_done", W), 64'd1, 64'd0);
                    end else begin
                        check($sformatf("w%0d_diff", W), 64'(diff), q_d[0]);
                        check($sformatf("w%0d_borrow", W), 64'(borrow), 64'(q_b[0]));
                        hold_d = q_d[0];
                        hold_b = q_b[0];
                        void'(q_e0.pop_front());
                        void'(q_d.pop_front());
                        void'(q_b.pop_front());
                    end
                end else begin
                    check($sformatf("w%0d_diff_hold", W), 64'(diff), hold_d);
                    check($sformatf("w%0d_borrow_hold", W), 64'(borrow), 64'(hold_b));
                end
            end
        end
    end

    initial begin
        int t;
        for (t = 0; t < 90000 && !(fin[0] && fin[1] && fin[2]); t++) @(posedge clk);
        if (!(fin[0] && fin[1] && fin[2])) check("timeout", 64'd1, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
